rr_onehot_arbiter: RTL

- Round-robin arbiter sharing one resource among 2^IDX_W requesters.
- Output is a registered one-hot grant vector plus the binary owner index (decoder-style mapping: idx k -> bit k).
- Sits in front of shared LC-3 datapath resources (memory port, bus drivers) so that exactly one source drives at a time.

---
 rtl/rr_onehot_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter with registered one-hot grant and binary owner index.
// Define RR_ARB_HOLD_LIMIT_EN to preempt an owner after MAX_HOLD cycles when others wait.
module rr_onehot_arbiter #(
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [(1<<IDX_W)-1:0]   req,
   output logic [(1<<IDX_W)-1:0]   gnt,
   output logic [IDX_W-1:0]        gnt_idx,
   output logic                    gnt_valid
);
   localparam int N = 1 << IDX_W;
   typedef enum logic {IDLE, OWNED} state_t;
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_onehot_arbiter: MAX_HOLD must be within 2..255");
   end
   state_t           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d, cand;
   logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d, win, k;
   logic             valid_q, valid_d, found, preempt, take;
`ifdef RR_ARB_HOLD_LIMIT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0]       cnt_q, cnt_d;
`endif
   // The owner is masked out, so a release or preemption picks someone else when possible.
   always_comb begin
      cand  = req & ~gnt_q;
      win   = last_q;
      found = 1'b0;
      k     = '0;
      for (int i = 1; i <= N; i++) begin
         k = last_q + IDX_W'(i);
         if (!found && cand[k]) begin
            win   = k;
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      valid_d = valid_q;
`ifdef RR_ARB_HOLD_LIMIT_EN
      cnt_d   = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + 8'd1;
      preempt = state_q == OWNED && cnt_q == HOLD_LAST && found;
`else
      preempt = 1'b0;
`endif
      take = state_q == IDLE || !req[idx_q] || preempt;
      if (take) begin
         state_d = found ? OWNED : IDLE;
         last_d  = found ? win : last_q;
         gnt_d   = found ? N'(1) << win : '0;
         idx_d   = found ? win : '0;
         valid_d = found;
`ifdef RR_ARB_HOLD_LIMIT_EN
         cnt_d   = '0;
`endif
      end
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q  <= '1;
         gnt_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end
   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;
endmodule
